// File: rtl/kp_alu_pkg.sv
// kp_alu_pkg
//   Shared definitions for the keypad / register-file / ALU datapath:
//   ALU operation codes, the keypad scanner state encoding, and a helper
//   that sizes register-file address ports.
package kp_alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL1 = 3'd5;
   localparam logic [2:0] OP_SHR1 = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } scan_state_t;

   // Address width for a register file of n entries (never narrower than 1 bit).
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/kp_scanner.sv
// kp_scanner
//   Self-timed matrix keypad scanner. Drives one column low at a time for
//   SCAN_DIV cycles, samples the rows at the end of each dwell, debounces a
//   detected row pattern over DEBOUNCE dwells, emits a single key_valid pulse
//   per press and waits for a debounced release before scanning again.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   kp_row      keypad rows, active-low
//   kp_col      column drive, active-low one-hot
//   key_valid   one-cycle pulse on an accepted keypress
//   key_code    row*COLS+col of the last accepted key
module kp_scanner
   import kp_alu_pkg::*;
#(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ROWS-1:0] kp_row,
   output logic [COLS-1:0] kp_col,
   output logic            key_valid,
   output logic [3:0]      key_code
);

   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DBW  = $clog2(DEBOUNCE + 1);

   scan_state_t      state;
   logic [CW-1:0]    col_idx;
   logic [DIVW-1:0]  div_cnt;
   logic [DBW-1:0]   deb_cnt;
   logic [ROWS-1:0]  row_pat;
   logic [3:0]       row_idx;
   logic             dwell_end;
   logic             all_high;
   logic [CW-1:0]    col_next;

   function automatic logic [3:0] lowest_low(input logic [ROWS-1:0] rows);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!rows[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   assign dwell_end = (div_cnt == DIVW'(SCAN_DIV - 1));
   assign all_high  = &kp_row;
   assign col_next  = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;

   always_comb begin
      kp_col = '1;
      for (int c = 0; c < COLS; c++) begin
         kp_col[c] = (col_idx != CW'(c));
      end
   end

   // The dwell divider free-runs in every state; only the column freezes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_SCAN;
         col_idx   <= '0;
         div_cnt   <= '0;
         deb_cnt   <= '0;
         row_pat   <= '1;
         row_idx   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         key_valid <= 1'b0;
         div_cnt   <= dwell_end ? '0 : div_cnt + 1'b1;
         case (state)
            ST_SCAN: begin
               if (dwell_end) begin
                  if (!all_high) begin
                     row_pat <= kp_row;
                     row_idx <= lowest_low(kp_row);
                     deb_cnt <= '0;
                     state   <= ST_DEBOUNCE;
                  end else begin
                     col_idx <= col_next;
                  end
               end
            end
            ST_DEBOUNCE: begin
               // row_pat always holds a low bit, so an all-high sample is a mismatch too.
               if (dwell_end) begin
                  if (kp_row != row_pat) begin
                     state   <= ST_SCAN;
                     col_idx <= col_next;
                  end else if (deb_cnt == DBW'(DEBOUNCE - 1)) begin
                     state     <= ST_PRESSED;
                     key_valid <= 1'b1;
                     key_code  <= 4'(int'(row_idx) * COLS + int'(col_idx));
                  end else begin
                     deb_cnt <= deb_cnt + 1'b1;
                  end
               end
            end
            ST_PRESSED: begin
               deb_cnt <= '0;
               state   <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (dwell_end) begin
                  if (!all_high) begin
                     deb_cnt <= '0;
                  end else if (deb_cnt == DBW'(DEBOUNCE - 1)) begin
                     state   <= ST_SCAN;
                     col_idx <= col_next;
                  end else begin
                     deb_cnt <= deb_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

endmodule

// File: rtl/kp_alu_datapath.sv
// kp_alu_datapath
//   Keypad-fed register file with an 8-operation ALU. Accepted keys shift a
//   nibble into reg[addr_wr]; exec evaluates the ALU on reg[addr_a] and
//   reg[addr_b], registers result and flags, and optionally writes the
//   result back to reg[addr_wr]. Writeback wins over a same-cycle key entry.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   gates key entry and exec
//   kp_row / kp_col       keypad rows (active-low in) / columns (active-low out)
//   op                    ALU operation
//   addr_a, addr_b        operand register addresses
//   addr_wr, wr_sel       destination for key entry / writeback, writeback enable
//   exec                  execute strobe
//   key_valid, key_code   accepted-key pulse and code
//   result, carry, zero, ovf  registered ALU outputs
module kp_alu_datapath
   import kp_alu_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 4,
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 4,
   localparam int AW      = addr_w(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [ROWS-1:0]  kp_row,
   output logic [COLS-1:0]  kp_col,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    addr_a,
   input  logic [AW-1:0]    addr_b,
   input  logic [AW-1:0]    addr_wr,
   input  logic             wr_sel,
   input  logic             exec,
   output logic             key_valid,
   output logic [3:0]       key_code,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             ovf
);

   logic [WIDTH-1:0]        regs [NUM_REGS];
   logic signed [WIDTH-1:0] opa_p0;
   logic signed [WIDTH-1:0] opb_p0;
   logic [WIDTH:0]          sum_p0;
   logic [WIDTH:0]          diff_p0;
   logic [WIDTH-1:0]        alu_res_p0;
   logic                    alu_carry_p0;
   logic                    alu_ovf_p0;
   logic                    vld_p0;
   logic                    wb_p0;
   logic                    key_wr_p0;
   logic [WIDTH-1:0]        result_p1;
   logic                    carry_p1;
   logic                    zero_p1;
   logic                    ovf_p1;

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] s);
      return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] d);
      return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
   endfunction

   kp_scanner #(
      .ROWS     (ROWS),
      .COLS     (COLS),
      .SCAN_DIV (SCAN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) u_scanner (
      .clk       (clk),
      .rst_n     (rst_n),
      .kp_row    (kp_row),
      .kp_col    (kp_col),
      .key_valid (key_valid),
      .key_code  (key_code)
   );

   // Stage p0: combinational register read and ALU evaluation.
   assign opa_p0    = regs[addr_a];
   assign opb_p0    = regs[addr_b];
   assign vld_p0    = exec & ena;
   assign wb_p0     = vld_p0 & wr_sel;
   assign key_wr_p0 = key_valid & ena;
   assign sum_p0    = {1'b0, opa_p0} + {1'b0, opb_p0};
   assign diff_p0   = {1'b0, opa_p0} - {1'b0, opb_p0};

   always_comb begin
      alu_res_p0   = opa_p0;
      alu_carry_p0 = 1'b0;
      alu_ovf_p0   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res_p0   = sum_p0[WIDTH-1:0];
            alu_carry_p0 = sum_p0[WIDTH];
            alu_ovf_p0   = add_ovf(opa_p0, opb_p0, sum_p0[WIDTH-1:0]);
         end
         OP_SUB: begin
            alu_res_p0   = diff_p0[WIDTH-1:0];
            alu_carry_p0 = diff_p0[WIDTH];
            alu_ovf_p0   = sub_ovf(opa_p0, opb_p0, diff_p0[WIDTH-1:0]);
         end
         OP_AND:  alu_res_p0 = opa_p0 & opb_p0;
         OP_OR:   alu_res_p0 = opa_p0 | opb_p0;
         OP_XOR:  alu_res_p0 = opa_p0 ^ opb_p0;
         OP_SHL1: begin
            alu_res_p0   = opa_p0 << 1;
            alu_carry_p0 = opa_p0[WIDTH-1];
         end
         OP_SHR1: begin
            alu_res_p0   = opa_p0 >> 1;
            alu_carry_p0 = opa_p0[0];
         end
         default: alu_res_p0 = opa_p0;
      endcase
   end

   // Stage p1: registered result/flags and register-file update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_p1 <= '0;
         carry_p1  <= 1'b0;
         zero_p1   <= 1'b0;
         ovf_p1    <= 1'b0;
      end else if (vld_p0) begin
         result_p1 <= alu_res_p0;
         carry_p1  <= alu_carry_p0;
         zero_p1   <= (alu_res_p0 == '0);
         ovf_p1    <= alu_ovf_p0;
      end
   end

   // Writeback takes priority; a coincident key nibble is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_p0) begin
         regs[addr_wr] <= alu_res_p0;
      end else if (key_wr_p0) begin
         regs[addr_wr] <= (regs[addr_wr] << 4) | WIDTH'(key_code);
      end
   end

   assign result = result_p1;
   assign carry  = carry_p1;
   assign zero   = zero_p1;
   assign ovf    = ovf_p1;

endmodule

// File: doc/kp_alu_datapath.md
Name: kp_alu_datapath

Overview:
Parametrised successor to the keypad/register-bank/ALU datapath. It contains:
- a self-timed matrix-keypad scanner with debounce and release detection;
- a NUM_REGS x WIDTH register file loaded nibble-by-nibble from keypad entries;
- an 8-operation ALU with a registered result and carry/zero/overflow flags, and optional writeback of the result into the register file.

It sits between the keypad pins and the result/flag outputs of the chip top.

Parameters:
- WIDTH, 8, datapath and register width; must be a multiple of 4 and at least 4.
- NUM_REGS, 4, register-file depth; power of 2, at least 2.
- ROWS, 4, keypad rows; ROWS*COLS must be at most 16.
- COLS, 4, keypad columns.
- SCAN_DIV, 16, clock cycles each column is driven (dwell period).
- DEBOUNCE, 4, consecutive dwell periods a row pattern must stay stable.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ena  in  1  block enable; while low, key entries and exec are ignored (scanner keeps running)
- kp_row  in  ROWS  keypad rows, active-low, externally pulled up
- kp_col  out  COLS  column drive, active-low one-hot
- op  in  3  ALU operation select
- addr_a  in  AW=$clog2(NUM_REGS)  operand A register address
- addr_b  in  AW  operand B register address
- addr_wr  in  AW  destination for key entry and writeback
- wr_sel  in  1  1 = exec writes the result back to addr_wr
- exec  in  1  execute strobe, level-sampled each cycle
- key_valid  out  1  single-cycle pulse on an accepted keypress
- key_code  out  4  code of the last accepted key
- result  out  WIDTH  registered ALU result
- carry  out  1  registered carry/borrow flag
- zero  out  1  registered zero flag
- ovf  out  1  registered signed-overflow flag

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: register file all 0; result, carry, zero, ovf, key_valid, key_code all 0; kp_col = all ones except bit 0 low; scanner in SCAN.
- Scanner FSM, states SCAN -> DEBOUNCE -> PRESSED -> RELEASE -> SCAN:
  - SCAN: advance the active column every SCAN_DIV cycles, wrapping COLS-1 -> 0. At the end of each dwell, if any kp_row bit is low, latch the column and the lowest-index low row, then go to DEBOUNCE with the column frozen.
  - DEBOUNCE: the identical row pattern must be sampled at the end of DEBOUNCE consecutive dwells.
    - Any mismatch, or all rows high: return to SCAN and resume at the next column.
    - Success: go to PRESSED.
  - PRESSED: lasts exactly one cycle. Assert key_valid and update key_code = row*COLS+col. Go to RELEASE.
  - RELEASE: the column stays frozen. Return to SCAN after DEBOUNCE consecutive dwells sample all rows high.
  - Any bounce during RELEASE restarts the release count. No repeat pulses are issued while a key is held.
- Key entry: in the cycle key_valid=1 with ena=1, reg[addr_wr] <= {reg[addr_wr][WIDTH-5:0], key_code} (left shift by one nibble).
- Exec: in a cycle with exec=1 and ena=1, the ALU reads reg[addr_a] and reg[addr_b] combinationally.
  - result and flags register on the next clk edge (latency 1); they hold their value otherwise.
  - If wr_sel=1, reg[addr_wr] takes the same result on that same edge.
  - Back-to-back exec is allowed every cycle. A read of an address written on the previous edge sees the new value.
- ALU operations (op), WIDTH-bit with wrap-around:
  - 0 ADD: carry = carry-out.
  - 1 SUB (A-B): carry = borrow (A<B unsigned).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL1: carry = A[WIDTH-1].
  - 6 SHR1 (logical): carry = A[0].
  - 7 PASS A.
  - carry = 0 for ops 2, 3, 4 and 7.
  - ovf = two's-complement overflow for ADD/SUB, else 0.
  - zero = (result == 0).
- Simultaneous key entry and writeback to the same addr_wr: the writeback wins and the key nibble is discarded. key_valid still pulses.
- Reset mid-scan or mid-debounce: the FSM returns to SCAN on column 0 and any partial key is lost.

Decomposition:
- Shared package kp_alu_pkg: 3-bit op constants (OP_ADD..OP_PASS), scanner state enum, and a function computing AW.
- One sub-module, kp_scanner: the column counter, dwell divider, debounce FSM, key_valid and key_code.
- The register file and ALU stay in kp_alu_datapath.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-dwell -> all outputs 0 immediately, kp_col=4'b1110, and no key_valid for at least COLS*SCAN_DIV cycles after release of reset.
- Clean press: hold row 2 low while col 1 is driven, ena=1, addr_wr=1 -> exactly one key_valid with key_code=9, reg1=8'h09. A second press of key 3 -> reg1=8'h93. Holding for 1000 cycles produces no repeat.
- Bounce: toggle row 0 every SCAN_DIV cycles for 3 dwells -> no key_valid. Then hold it stable -> key_valid after DEBOUNCE dwells.
- ALU: reg0=8'h7F, reg1=8'h01.
  - ADD -> result=8'h80, ovf=1, carry=0, zero=0, one cycle after exec.
  - SUB reg1-reg0 -> 8'h82, carry=1.
  - XOR reg0,reg0 -> 8'h00, zero=1.
- Writeback and forwarding: exec ADD with wr_sel=1, addr_wr=2, followed next cycle by exec PASS with addr_a=2 -> second result equals the first.
- Collision: key_valid and exec/wr_sel=1 to the same address in the same cycle -> the register holds the ALU result and the nibble is dropped. With ena=0, a keypress pulses key_valid but leaves the register file unchanged.
